rr_grant_encoder: RTL and testbench

- 4-requester round-robin arbiter; produces a registered 2-bit grant index plus a valid flag.
- Sits directly upstream of the 2-to-4 one-hot decoder stage: grant_idx drives the decoder select, and grant_valid gates its output.
- Fair rotation, a grant held until release, and a hold-time watchdog so one requester cannot starve the others.

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 28 ++
 rtl/rr_grant_encoder.sv | 95 +++++++++
 tb/tb_rr_grant_encoder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-requester round-robin grant encoder.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Modulo-N_REQ increment; relies on IDX_W-bit wrap since N_REQ == 2**IDX_W.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick: first set request at or after i_ptr, wrapping 3->0.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    o_any  = 1'b0;
    o_idx  = '0;
    w_cand = '0;
    // Walk from farthest offset to nearest so the nearest set bit is written last and wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = i_ptr + IDX_W'(k);
      if (i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter with registered grant index/valid, hold-until-release and a hold watchdog.
module rr_grant_encoder
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_release,
  output logic             o_grant_valid,
  output logic [IDX_W-1:0] o_grant_idx,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_grant_valid;
  logic [IDX_W-1:0] r_grant_idx;
  logic             r_timeout;

  logic             w_any;
  logic [IDX_W-1:0] w_pick_idx;
  logic [IDX_W-1:0] w_pick_ptr;
  logic             w_held;
  logic             w_wd;
  logic             w_exit;
  logic             w_timeout;

  // In GRANT the search starts past the grantee, so it is only re-picked when it is the sole requester.
  assign w_pick_ptr = (r_state == GRANT) ? wrap_inc(r_grant_idx) : r_ptr;

  rr_pick u_pick (
    .i_req (i_req),
    .i_ptr (w_pick_ptr),
    .o_any (w_any),
    .o_idx (w_pick_idx)
  );

  assign w_held    = i_req[r_grant_idx];
  assign w_wd      = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST);
  assign w_exit    = i_release | ~w_held | w_wd;
  // Release and abandonment take precedence, so the pulse only marks a genuine revocation.
  assign w_timeout = ~i_release & w_held & w_wd;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
      r_timeout     <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state       <= GRANT;
            r_grant_valid <= 1'b1;
            r_grant_idx   <= w_pick_idx;
            r_cnt         <= '0;
          end
        end
        GRANT: begin
          if (w_exit) begin
            r_ptr     <= wrap_inc(r_grant_idx);
            r_timeout <= w_timeout;
            r_cnt     <= '0;
            if (w_any) begin
              r_grant_idx <= w_pick_idx;
            end else begin
              r_state       <= IDLE;
              r_grant_valid <= 1'b0;
              r_grant_idx   <= '0;
            end
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_grant_valid = r_grant_valid;
  assign o_grant_idx   = r_grant_idx;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder: reset, rotation, wrap/skip, watchdog, priorities, mid-grant reset.
module tb_rr_grant_encoder;
  import arb_pkg::*;

  logic             clk;
  logic             rst_n;
  logic [N_REQ-1:0] req;
  logic             rel;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             timeout;

  int checks   = 0;
  int failures = 0;

  rr_grant_encoder #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (req),
    .i_release     (rel),
    .o_grant_valid (grant_valid),
    .o_grant_idx   (grant_idx),
    .o_timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] idx, input logic to);
    check({tag, ".valid"}, 32'(grant_valid), 32'(v));
    check({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    check({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    rel   = 1'b0;
    #1;

    // Reset held two cycles
    tick(); check_out("rst_c1", 1'b0, 2'd0, 1'b0);
    tick(); check_out("rst_c2", 1'b0, 2'd0, 1'b0);

    // Single request, one-cycle latency
    rst_n = 1'b1; req = 4'b0100;
    tick(); check_out("single_grant", 1'b1, 2'd2, 1'b0);
    tick(); check_out("single_hold", 1'b1, 2'd2, 1'b0);
    rel = 1'b1; req = 4'b0000;
    tick(); check_out("single_release", 1'b0, 2'd0, 1'b0);

    // ptr=3, req=0011: 0 then 1, requester 3 never granted
    rel = 1'b0; req = 4'b0011;
    tick(); check_out("wrap_g0", 1'b1, 2'd0, 1'b0);
    rel = 1'b1;
    tick(); check_out("wrap_g1", 1'b1, 2'd1, 1'b0);
    tick(); check_out("skip3_g0", 1'b1, 2'd0, 1'b0);
    req = 4'b0000;
    tick(); check_out("wrap_idle", 1'b0, 2'd0, 1'b0);

    // Bring ptr to 0 via a grant to requester 3
    rel = 1'b0; req = 4'b1000;
    tick(); check_out("g3", 1'b1, 2'd3, 1'b0);
    rel = 1'b1; req = 4'b0000;
    tick(); check_out("g3_release", 1'b0, 2'd0, 1'b0);

    // Round robin with all requesting, release every grant
    rel = 1'b0; req = 4'b1111;
    tick(); check_out("rr_0", 1'b1, 2'd0, 1'b0);
    rel = 1'b1;
    tick(); check_out("rr_1", 1'b1, 2'd1, 1'b0);
    tick(); check_out("rr_2", 1'b1, 2'd2, 1'b0);
    tick(); check_out("rr_3", 1'b1, 2'd3, 1'b0);
    tick(); check_out("rr_0b", 1'b1, 2'd0, 1'b0);

    // Watchdog: requester 0 just granted, no release
    rel = 1'b0; req = 4'b0011;
    for (int i = 0; i < 15; i++) begin
      tick(); check_out("wd_hold", 1'b1, 2'd0, 1'b0);
    end
    tick(); check_out("wd_expire", 1'b1, 2'd1, 1'b1);
    tick(); check_out("wd_pulse_end", 1'b1, 2'd1, 1'b0);

    // Abandonment: requester 1 drops, requester 0 granted next edge
    req = 4'b0001;
    tick(); check_out("abandon", 1'b1, 2'd0, 1'b0);

    // Sole requester re-granted by watchdog
    for (int i = 0; i < 15; i++) begin
      tick(); check_out("sole_hold", 1'b1, 2'd0, 1'b0);
    end
    tick(); check_out("sole_regrant", 1'b1, 2'd0, 1'b1);

    // Counter restarted: release on the new expiry edge wins over watchdog
    req = 4'b0011;
    for (int i = 0; i < 15; i++) begin
      tick(); check_out("restart_hold", 1'b1, 2'd0, 1'b0);
    end
    rel = 1'b1;
    tick(); check_out("rel_vs_wd", 1'b1, 2'd1, 1'b0);

    // Hand to requester 2, then reset mid-grant
    rel = 1'b0; req = 4'b0100;
    tick(); check_out("to_g2", 1'b1, 2'd2, 1'b0);
    rst_n = 1'b0;
    tick(); check_out("mid_reset", 1'b0, 2'd0, 1'b0);
    rst_n = 1'b1; req = 4'b1100;
    tick(); check_out("post_reset", 1'b1, 2'd2, 1'b0);

    // Non-granted bits changing do not disturb the grant
    req = 4'b0111;
    tick(); check_out("other_bits", 1'b1, 2'd2, 1'b0);

    // Release to idle, then release while idle is ignored
    rel = 1'b1; req = 4'b0000;
    tick(); check_out("final_idle", 1'b0, 2'd0, 1'b0);
    tick(); check_out("idle_release", 1'b0, 2'd0, 1'b0);
    rel = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
